// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 command sequencer: default data width and ALU op encodings.
`timescale 1ns/100ps
package alu32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu32_rsp_fifo.sv
// Response FIFO for the alu32 sequencer: WIDTH x DEPTH, registered occupancy count, async reset.
`timescale 1ns/100ps
module alu32_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  import alu32_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is masked to zero when empty so stale entries never leak out.
  assign rd_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && (count_q == CW'(DEPTH))));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(rd_en && (count_q == '0)));

endmodule

// File: rtl/alu32_cmd_sequencer.sv
// Streams operand commands into a registered alu32 and returns its results in order
// through a credit-limited response FIFO.
`timescale 1ns/100ps
module alu32_cmd_sequencer #(
  parameter int WIDTH     = alu32_pkg::WIDTH,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      issue_count
);
  import alu32_pkg::*;

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [ALU_LAT:0] tag_q, tag_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [15:0]      issue_count_q, issue_count_d;

  logic [CW-1:0]    occupancy;
  logic             accept;
  logic             capture;
  logic             pop;

  // Credits count both in-flight ops and buffered results, so the FIFO can never overflow.
  assign cmd_ready = ({1'b0, inflight_q} + {1'b0, occupancy}) < (CW+1)'(RSP_DEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = tag_q[ALU_LAT];
  assign rsp_valid = (occupancy != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    inflight_d    = inflight_q;
    issue_count_d = issue_count_q;
    tag_d         = (tag_q << 1) | (ALU_LAT+1)'(accept);
    if (accept) begin
      alu_a_d       = cmd_a;
      alu_b_d       = cmd_b;
      alu_sel_d     = cmd_sel;
      issue_count_d = issue_count_q + 16'd1;
    end
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= 2'b00;
      tag_q         <= '0;
      inflight_q    <= '0;
      issue_count_q <= '0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      tag_q         <= tag_d;
      inflight_q    <= inflight_d;
      issue_count_q <= issue_count_d;
    end
  end

  alu32_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (alu_out),
    .rd_en   (pop),
    .rd_data (rsp_data),
    .count   (occupancy)
  );

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign busy        = (inflight_q != '0) || (occupancy != '0);
  assign issue_count = issue_count_q;

endmodule
